// File: rtl/rvic_pkg.sv
// Shared RVIC types: source vector width and acknowledge ID encoding.
package rvic_pkg;
    localparam int unsigned RVIC_MAX_SRC = 32;
    localparam int unsigned RVIC_ID_W    = 8;

    typedef logic [RVIC_ID_W-1:0]    rvic_id_t;
    typedef logic [RVIC_MAX_SRC-1:0] rvic_src_t;
endpackage

// File: rtl/rvic_gateway_if.sv
// Raw-line / acknowledge / conditioned-source bundle between a peripheral side and the gateway.
interface rvic_gateway_if;
    import rvic_pkg::*;

    rvic_src_t raw;
    logic      ack_valid;
    rvic_id_t  ack_id;
    rvic_src_t src;

    modport master (output raw, output ack_valid, output ack_id, input  src);
    modport slave  (input  raw, input  ack_valid, input  ack_id, output src);
endinterface

// File: rtl/rvic_gw_chan.sv
// One interrupt source: 2-flop synchroniser, optional glitch filter (RVIC_GW_FILTER_EN),
// then a level pass-through or a sticky rising-edge pending bit cleared by acknowledge.
module rvic_gw_chan #(
    parameter bit          EDGE          = 1'b0,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic ack_i,
    output logic src_o
);
    logic s1_q, s2_q;
    logic f;
    logic out_q, out_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

`ifdef RVIC_GW_FILTER_EN
    localparam logic [3:0] CNT_MAX = 4'(FILTER_CYCLES - 1);

    logic       f_q, f_d;
    logic [3:0] cnt_q, cnt_d;

    // cnt counts consecutive samples disagreeing with f; it resets before it could wrap
    always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        if (s2_q == f_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            f_d   = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign f = f_q;
`else
    assign f = s2_q;
`endif

    if (EDGE) begin : g_edge
        logic fd_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) fd_q <= 1'b0;
            else         fd_q <= f;
        end

        // a fresh rise beats a simultaneous acknowledge so the new edge is never lost
        always_comb begin
            out_d = out_q;
            if (f && !fd_q) out_d = 1'b1;
            else if (ack_i) out_d = 1'b0;
        end
    end else begin : g_level
        always_comb begin
            out_d = f;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) out_q <= 1'b0;
        else         out_q <= out_d;
    end

    assign src_o = out_q;
endmodule

// File: rtl/rvic_gateway.sv
// Interrupt source gateway in front of the RVIC: NUM_SRC conditioned channels plus ack-ID decode.
// Glitch filter is compiled in with `define RVIC_GW_FILTER_EN.
module rvic_gateway
    import rvic_pkg::*;
#(
    parameter int unsigned  NUM_SRC       = 32,
    parameter logic [31:0]  EDGE_MASK     = 32'h0,
    parameter int unsigned  FILTER_CYCLES = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  rvic_src_t raw_i,
    input  logic      ack_valid_i,
    input  rvic_id_t  ack_id_i,
    output rvic_src_t src_o
);
    logic [NUM_SRC-1:0] ack_clr;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_chan
        // IDs at or above NUM_SRC match no channel and are silently dropped
        assign ack_clr[n] = ack_valid_i && (ack_id_i == RVIC_ID_W'(n));

        rvic_gw_chan #(
            .EDGE          (EDGE_MASK[n]),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .raw_i  (raw_i[n]),
            .ack_i  (ack_clr[n]),
            .src_o  (src_o[n])
        );
    end

    if (NUM_SRC < RVIC_MAX_SRC) begin : g_tie
        assign src_o[RVIC_MAX_SRC-1:NUM_SRC] = '0;
    end
endmodule
